// File: rtl/piso_tx_pkg.sv
// rtl/piso_tx_pkg.sv - shared multiplier datapath constants and PISO state encodings
package piso_tx_pkg;

  // Operand register width of the multiplier PIPO datapath.
  localparam int unsigned PIPO_WIDTH = 16;

  // The serializer drains one PIPO operand word by default.
  localparam int unsigned PISO_WIDTH_DEF = PIPO_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } piso_state_e;

endpackage

// File: rtl/piso_tx_bit_cntr.sv
// rtl/piso_tx_bit_cntr.sv - bit counter with clear, enable and terminal count
module bit_cntr #(
  parameter int unsigned N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [$clog2(N)-1:0] r_cnt;

  // Count enabled events; saturate at N-1 so the count never wraps inside a word.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en && !tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tc = (r_cnt == ($clog2(N))'(N - 1));

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with stall support
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             ld,
  input  logic             en,
  output logic             sout,
  output logic             sout_vld,
  output logic             busy,
  output logic             done
);

  piso_state_e      r_state;
  piso_state_e      w_next;
  logic [WIDTH-1:0] r_shreg;
  logic             w_load;
  logic             w_xfer;
  logic             w_tc;
  logic             w_head;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, datapath strobes, and outputs decoded from the current state only.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_xfer   = 1'b0;
    sout_vld = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ld) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        sout_vld = 1'b1;
        if (en) begin
          w_xfer = 1'b1;
          if (w_tc) begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_head = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign sout   = sout_vld & w_head;

  // Shift register: capture on load, move one bit toward the head on each accepted bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (w_load) begin
      r_shreg <= din;
    end else if (w_xfer) begin
      if (MSB_FIRST) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end
    end
  end

  bit_cntr #(
    .N(WIDTH)
  ) u_bit_cntr (
    .clk (clk),
    .rst (rst),
    .clr (w_load),
    .en  (w_xfer),
    .tc  (w_tc)
  );

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed self-checking bench for piso_tx
module tb_piso_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        ld;
  logic        en;
  logic        sout;
  logic        sout_vld;
  logic        busy;
  logic        done;

  logic [15:0] din2;
  logic        ld2;
  logic        en2;
  logic        sout2;
  logic        sout_vld2;
  logic        busy2;
  logic        done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso_tx #(
    .WIDTH     (16),
    .MSB_FIRST (1'b1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .ld       (ld),
    .en       (en),
    .sout     (sout),
    .sout_vld (sout_vld),
    .busy     (busy),
    .done     (done)
  );

  piso_tx #(
    .WIDTH     (16),
    .MSB_FIRST (1'b0)
  ) u_dut_lsb (
    .clk      (clk),
    .rst      (rst),
    .din      (din2),
    .ld       (ld2),
    .en       (en2),
    .sout     (sout2),
    .sout_vld (sout_vld2),
    .busy     (busy2),
    .done     (done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vld"}, sout_vld, 0);
    chk({tag, "_sout"}, sout, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Entered in the first SHIFT cycle; returns in the DONE cycle.
  task automatic rx_word(input logic [15:0] exp_w, input bit toggle, input int glitch_bit);
    int idx = 0;
    int cyc = 0;
    while (idx < 16 && cyc < 100) begin
      chk("vld", sout_vld, 1);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk($sformatf("bit%0d", idx), sout, exp_w[15-idx]);
      en = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (glitch_bit >= 0) begin
        ld = (idx == glitch_bit);
        if (ld) din = 16'h3456;
      end
      tick();
      if (en) idx++;
      cyc++;
    end
    if (glitch_bit >= 0) ld = 1'b0;
    en = 1'b1;
    chk("rx_bits", idx, 16);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_vld", sout_vld, 0);
    chk("done_sout", sout, 0);
  endtask

  initial begin
    logic [15:0] lsb_w;

    // Reset with ld/en asserted: reset must win.
    rst = 1'b1; ld = 1'b1; en = 1'b1; din = 16'h3451;
    ld2 = 1'b0; en2 = 1'b0; din2 = 16'h0000;
    tick();
    tick();
    chk_idle("rst");
    rst = 1'b0; ld = 1'b0;
    tick();
    chk_idle("post_rst");

    // Plain word, continuous enable.
    din = 16'h3451; ld = 1'b1; en = 1'b1;
    tick();
    ld = 1'b0;
    rx_word(16'h3451, 1'b0, -1);
    tick();
    chk_idle("w1_end");

    // Stalling sink.
    ld = 1'b1;
    tick();
    ld = 1'b0;
    rx_word(16'h3451, 1'b1, -1);
    tick();
    chk_idle("w2_end");

    // ld pulse mid-word is ignored and nothing is queued.
    din = 16'h3451; ld = 1'b1;
    tick();
    ld = 1'b0;
    rx_word(16'h3451, 1'b0, 5);
    tick();
    chk_idle("w3_end");
    tick();
    chk_idle("w3_noq");

    // ld held high: back-to-back words with a two-cycle gap.
    din = 16'h3456; ld = 1'b1;
    tick();
    rx_word(16'h3456, 1'b0, -1);
    tick();
    chk_idle("gap");
    tick();
    rx_word(16'h3456, 1'b0, -1);
    ld = 1'b0;
    tick();
    chk_idle("b2b_end");

    // Reset mid-word aborts without done; next ld honoured right after reset.
    din = 16'hFFFF; ld = 1'b1;
    tick();
    ld = 1'b0;
    repeat (8) tick();
    chk("abort_bit8", sout, 1);
    chk("abort_vld", sout_vld, 1);
    rst = 1'b1;
    tick();
    chk_idle("abort");
    rst = 1'b0; ld = 1'b1; din = 16'h3451;
    tick();
    ld = 1'b0;
    rx_word(16'h3451, 1'b0, -1);
    tick();
    chk_idle("w5_end");

    // LSB-first instance.
    lsb_w = 16'h0001;
    din2 = lsb_w; ld2 = 1'b1; en2 = 1'b1;
    tick();
    ld2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("lsb_bit%0d", i), sout2, lsb_w[i]);
      chk("lsb_vld", sout_vld2, 1);
      tick();
    end
    chk("lsb_done", done2, 1);
    chk("lsb_done_vld", sout_vld2, 0);
    tick();
    chk("lsb_idle_busy", busy2, 0);
    chk("lsb_idle_done", done2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 16: data word width; shall be >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB shifted first.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 ld  input  1  load strobe; captures din when accepted.
REQ-007 en  input  1  shift enable from serial sink; 0 = stall.
REQ-008 sout  output  1  serial data bit.
REQ-009 sout_vld  output  1  sout carries a valid bit this cycle.
REQ-010 busy  output  1  word in flight; ld ignored.
REQ-011 done  output  1  one-cycle pulse after last bit is accepted.

Function
REQ-012 FSM shall have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE: busy=0, sout_vld=0; ld=1 at an edge shall load din into shift register, clear bit counter, and go to SHIFT.
REQ-014 SHIFT: busy=1, sout_vld=1, sout = current head bit (din[WIDTH-1] first if MSB_FIRST=1, din[0] first otherwise).
REQ-015 Latency: first bit shall appear on sout in the cycle immediately after the ld edge; no additional pipeline delay.
REQ-016 In SHIFT, an edge with en=1 shall count the head bit as transferred, shift the register by one toward the head, and increment the counter.
REQ-017 In SHIFT, an edge with en=0 shall hold register, counter, and sout unchanged; stall length shall be unbounded.
REQ-018 When the edge with en=1 transfers bit index WIDTH-1, the FSM shall go to DONE; exactly WIDTH bits shall be transferred per word.
REQ-019 DONE: done=1, busy=1, sout_vld=0 for exactly one cycle, then IDLE unconditionally.
REQ-020 ld while busy=1, including in DONE, shall be ignored; din is not sampled and no word is queued.
REQ-021 ld held high across the DONE to IDLE boundary shall load a new word at the first IDLE edge; back-to-back words therefore have a 2-cycle gap (DONE plus the IDLE load edge).
REQ-022 Bit counter width shall be clog2(WIDTH) and shall never wrap within a word.
REQ-023 Vacated register bits shall fill with 0; sout shall be 0 whenever sout_vld=0.

Reset
REQ-024 rst=1 at an edge shall force IDLE, shift register=0, counter=0, sout=0, sout_vld=0, busy=0, done=0.
REQ-025 rst shall take priority over ld and en; rst mid-word shall abort the word with no done pulse.
REQ-026 The first ld after rst deasserts shall be honoured at the first edge where rst=0.

Structure
REQ-027 State encodings and the WIDTH default shall live in the shared multiplier package or include, alongside the PIPO/datapath constants.
REQ-028 The bit counter shall be one sub-module, bit_cntr (clear, enable, terminal-count output), reusable by the multiplier controller.
REQ-029 Outputs busy, done, sout_vld shall be decoded from registered state only; no combinational path from ld or en to any output.

Verification
REQ-030 WIDTH=16, MSB_FIRST=1, din=16'h3451, ld pulse, en=1 -> sout over 16 cycles 0011_0100_0101_0001, sout_vld high 16 cycles, done on cycle 17.
REQ-031 Same word, en toggled 1,0,1,0... -> same bit sequence, each bit held while en=0, done after 16 en=1 edges.
REQ-032 Load 16'h3451; ld pulse with din=16'h3456 on bit 5 -> output remains 16'h3451 sequence; second word not sent.
REQ-033 ld held high continuously with din=16'h3456 -> two identical words, 2-cycle gap between last bit and next first bit.
REQ-034 rst asserted at bit 8 of 16'hFFFF -> next cycle sout=0, sout_vld=0, busy=0, no done pulse; subsequent ld sends a full word correctly.
REQ-035 MSB_FIRST=0, din=16'h0001 -> sout=1 on the first bit, 0 on the remaining 15.
